// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection: load in EX writes a register the ID instruction reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                 ex_memread_i,
  input  logic [REG_IDX_W-1:0] ex_rt_i,
  input  logic [REG_IDX_W-1:0] id_rs_i,
  input  logic [REG_IDX_W-1:0] id_rt_i,
  input  logic                 id_uses_rt_i,
  output logic                 lu_o
);

  // $zero is never a real dependency.
  assign lu_o = ex_memread_i && (ex_rt_i != REG_ZERO) &&
                ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: D-cache miss freeze, load-use bubble, branch/jump flush.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REG_IDX_W-1:0] id_rs_i,
  input  logic [REG_IDX_W-1:0] id_rt_i,
  input  logic                 id_uses_rt_i,
  input  logic                 ex_memread_i,
  input  logic [REG_IDX_W-1:0] ex_rt_i,
  input  logic                 branch_taken_i,
  input  logic                 jump_i,
  input  logic                 dcache_req_i,
  input  logic                 dcache_ack_i,
  output logic                 pc_write_o,
  output logic                 ifid_hazard_o,
  output logic                 ifid_flush_o,
  output logic                 ifid_stall_o,
  output logic                 idex_bubble_o,
  output logic                 pipe_stall_o,
  output logic                 mem_timeout_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]     perf_memstall_o,
  output logic [CNT_W-1:0]     perf_bubble_o,
  output logic [CNT_W-1:0]     perf_flush_o
`endif
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(MEM_TIMEOUT - 2);

  if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
    $error("pipe_hazard_ctrl: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              mem_timeout_q;
  logic              memstall;
  logic              lu;

  hazard_detect u_hazard_detect (
    .ex_memread_i (ex_memread_i),
    .ex_rt_i      (ex_rt_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_uses_rt_i (id_uses_rt_i),
    .lu_o         (lu)
  );

  // Next state and priority mux: memstall > load-use > flush.
  always_comb begin
    state_d       = state_q;
    memstall      = 1'b0;
    pc_write_o    = 1'b1;
    ifid_hazard_o = 1'b0;
    ifid_flush_o  = 1'b0;
    ifid_stall_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_stall_o  = 1'b0;

    case (state_q)
      S_RUN: begin
        if (dcache_req_i && !dcache_ack_i) begin
          memstall = 1'b1;
          state_d  = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (dcache_ack_i) state_d = S_RUN;
        else              memstall = 1'b1;
      end
      default: state_d = S_RUN;
    endcase

    if (memstall) begin
      pc_write_o   = 1'b0;
      ifid_stall_o = 1'b1;
      pipe_stall_o = 1'b1;
    end else if (lu) begin
      pc_write_o    = 1'b0;
      ifid_hazard_o = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i || jump_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // State, saturating miss-wait counter and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_RUN && state_d == S_MEM_WAIT) begin
        wait_cnt_q <= '0;
      end else if (state_q == S_MEM_WAIT && !dcache_ack_i) begin
        if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_q == WAIT_PRE) mem_timeout_q <= 1'b1;
      end
    end
  end

  assign mem_timeout_o = mem_timeout_q;

`ifdef PIPE_HAZARD_PERF_EN
  // Saturating counts of the cycles each condition won priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_memstall_o <= '0;
      perf_bubble_o   <= '0;
      perf_flush_o    <= '0;
    end else begin
      if (pipe_stall_o  && perf_memstall_o != '1) perf_memstall_o <= perf_memstall_o + CNT_W'(1);
      if (idex_bubble_o && perf_bubble_o   != '1) perf_bubble_o   <= perf_bubble_o + CNT_W'(1);
      if (ifid_flush_o  && perf_flush_o    != '1) perf_flush_o    <= perf_flush_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model. Perf counters checked when PIPE_HAZARD_PERF_EN is set.
module tb_pipe_hazard_ctrl;

  localparam int unsigned T  = 4;
  localparam int unsigned CW = 16;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
  logic       id_uses_rt_i, ex_memread_i, branch_taken_i, jump_i;
  logic       dcache_req_i, dcache_ack_i;
  logic       pc_write_o, ifid_hazard_o, ifid_flush_o, ifid_stall_o;
  logic       idex_bubble_o, pipe_stall_o, mem_timeout_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [CW-1:0] perf_memstall_o, perf_bubble_o, perf_flush_o;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rt_i        (ex_rt_i),
    .branch_taken_i (branch_taken_i),
    .jump_i         (jump_i),
    .dcache_req_i   (dcache_req_i),
    .dcache_ack_i   (dcache_ack_i),
    .pc_write_o     (pc_write_o),
    .ifid_hazard_o  (ifid_hazard_o),
    .ifid_flush_o   (ifid_flush_o),
    .ifid_stall_o   (ifid_stall_o),
    .idex_bubble_o  (idex_bubble_o),
    .pipe_stall_o   (pipe_stall_o),
    .mem_timeout_o  (mem_timeout_o)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_memstall_o(perf_memstall_o),
    .perf_bubble_o  (perf_bubble_o),
    .perf_flush_o   (perf_flush_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int errors  = 0;

  // Reference model: is a miss outstanding, how many stalled cycles it has cost so far.
  bit m_miss;
  int m_stalls;
  bit m_to;
  int m_pm, m_pb, m_pf;

  // Output vector order: {pc_write, ifid_hazard, ifid_flush, ifid_stall, idex_bubble, pipe_stall, mem_timeout}
  function automatic logic [6:0] obs();
    return {pc_write_o, ifid_hazard_o, ifid_flush_o, ifid_stall_o,
            idex_bubble_o, pipe_stall_o, mem_timeout_o};
  endfunction

  function automatic logic [6:0] ref_out();
    bit ms, lu;
    logic [6:0] r;
    ms = m_miss ? !dcache_ack_i : (dcache_req_i && !dcache_ack_i);
    lu = ex_memread_i && (ex_rt_i != 5'd0) &&
         ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    if (ms)                          r = 7'b0001010;
    else if (lu)                     r = 7'b0100100;
    else if (branch_taken_i || jump_i) r = 7'b1010000;
    else                             r = 7'b1000000;
    r[0] = m_to;
    return r;
  endfunction

  task automatic model_step();
    logic [6:0] r;
    r = ref_out();
    if (rst_i) begin
      m_miss = 0; m_stalls = 0; m_to = 0; m_pm = 0; m_pb = 0; m_pf = 0;
    end else if (r[1]) begin
      m_stalls = (m_miss ? m_stalls : 0) + 1;
      m_miss   = 1;
      if (m_stalls >= int'(T)) m_to = 1;
      m_pm++;
    end else begin
      m_miss = 0;
      if (r[2]) m_pb++;
      if (r[4]) m_pf++;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic drive(input bit rst, input logic [4:0] rs, input logic [4:0] rt, input bit uses,
                       input bit mr, input logic [4:0] ert, input bit br, input bit jmp,
                       input bit req, input bit ack);
    rst_i = rst; id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = uses; ex_memread_i = mr;
    ex_rt_i = ert; branch_taken_i = br; jump_i = jmp; dcache_req_i = req; dcache_ack_i = ack;
  endtask

  task automatic test_reset();
    logic [6:0] o;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    o = obs(); vectors++;
    if (o !== 7'b1000000) begin errors++; $display("FAIL reset_idle got=%b exp=%b", o, 7'b1000000); end
    tick();
  endtask

  task automatic test_load_use();
    logic [6:0] o;
    logic [6:0] exp_q[$];
    exp_q = '{7'b0100100, 7'b1000000, 7'b1000000, 7'b1000000, 7'b0100100};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(0, 8, 1, 0, 1, 8, 0, 0, 0, 0);  // rs hit on load
        1: drive(0, 8, 1, 0, 0, 8, 0, 0, 0, 0);  // load has left EX
        2: drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);  // $zero never hazards
        3: drive(0, 3, 9, 0, 1, 9, 0, 0, 0, 0);  // rt match but rt unused
        default: drive(0, 3, 9, 1, 1, 9, 0, 0, 0, 0);
      endcase
      @(negedge clk_i);
      o = obs(); vectors++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL load_use[%0d] got=%b exp=%b", i, o, exp_q[i]); end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [6:0] o;
    logic [6:0] exp_q[$];
    exp_q = '{7'b1010000, 7'b1010000, 7'b0100100, 7'b1010000};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(0, 4, 5, 1, 0, 0, 1, 0, 0, 0);
        1: drive(0, 4, 5, 1, 0, 0, 0, 1, 0, 0);
        2: drive(0, 4, 5, 1, 1, 5, 1, 0, 0, 0);  // branch loses to load-use
        default: drive(0, 4, 5, 1, 0, 5, 1, 0, 0, 0);
      endcase
      @(negedge clk_i);
      o = obs(); vectors++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL flush[%0d] got=%b exp=%b", i, o, exp_q[i]); end
      tick();
    end
  endtask

  // 5-cycle miss with branch and load-use pending, then ack, then a hit.
  task automatic test_miss();
    logic [6:0] o, e;
    for (int i = 0; i < 8; i++) begin
      if (i < 5)       drive(0, 8, 0, 0, 1, 8, 1, 0, 1, 0);
      else if (i == 5) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      else if (i == 6) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      else             drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (i < 4)       e = 7'b0001010;
      else if (i == 4) e = 7'b0001011;
      else             e = 7'b1000001;
      @(negedge clk_i);
      o = obs(); vectors++;
      if (o !== e) begin errors++; $display("FAIL miss[%0d] got=%b exp=%b", i, o, e); end
      tick();
    end
  endtask

  // Timeout stays sticky; reset mid-miss clears it and returns to run at once.
  task automatic test_timeout();
    logic [6:0] o;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk_i);
    o = obs(); vectors++;
    if (o !== 7'b0001011) begin errors++; $display("FAIL timeout_sticky got=%b exp=%b", o, 7'b0001011); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    o = obs(); vectors++;
    if (o !== 7'b1000000) begin errors++; $display("FAIL timeout_reset got=%b exp=%b", o, 7'b1000000); end
    tick();
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  task automatic test_perf();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 0); tick(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    drive(0, 8, 0, 0, 1, 8, 1, 0, 0, 0); tick();
    drive(0, 8, 0, 0, 0, 8, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    vectors++;
    if (perf_memstall_o !== CW'(5) || perf_bubble_o !== CW'(1) || perf_flush_o !== CW'(1)) begin
      errors++;
      $display("FAIL perf_directed got=%0d/%0d/%0d exp=5/1/1", perf_memstall_o, perf_bubble_o, perf_flush_o);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [6:0] o, e;
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 2, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4);
      @(negedge clk_i);
      o = obs(); e = ref_out(); vectors++;
      if (o !== e) begin errors++; $display("FAIL random[%0d] got=%b exp=%b", i, o, e); end
      tick();
    end
`ifdef PIPE_HAZARD_PERF_EN
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    vectors++;
    if (perf_memstall_o !== CW'(m_pm) || perf_bubble_o !== CW'(m_pb) || perf_flush_o !== CW'(m_pf)) begin
      errors++;
      $display("FAIL perf_random got=%0d/%0d/%0d exp=%0d/%0d/%0d",
               perf_memstall_o, perf_bubble_o, perf_flush_o, m_pm, m_pb, m_pf);
    end
`endif
  endtask

  initial begin
    m_miss = 0; m_stalls = 0; m_to = 0; m_pm = 0; m_pb = 0; m_pf = 0;
    test_reset();
    test_load_use();
    test_flush();
    test_miss();
    test_timeout();
`ifdef PIPE_HAZARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
